// File: rtl/hex_display_multi.sv
// Multi-digit seven-segment display driver.
// Captures a binary value on a load strobe and renders it either as hex or
// as decimal (sequential double-dabble conversion, one bit per clock).
// Provides leading-zero blanking, an overflow dash display and a busy/done
// handshake. Segments are active-low: bit0 = a .. bit6 = g.
module hex_display_multi #(
    parameter int DIGITS = 6,   // number of digits driven, 1..8
    parameter int WIDTH  = 20   // width of the binary input, 1..32
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      value,
    input  logic                  load,
    input  logic                  mode,
    input  logic                  blank_lz,
    output logic [7*DIGITS-1:0]   HEX,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;                    // BCD / nibble field width
    localparam int PW = (WIDTH > BW) ? WIDTH : BW;     // value padded to cover every digit
    localparam int CW = $clog2(WIDTH + 1);             // shift counter width

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } state_t;

    // Largest decimal value that fits in DIGITS digits; 34 bits so that
    // 10^8 - 1 is held without truncation.
    function automatic logic [33:0] dec_limit(input int n);
        logic [33:0] p;
        p = 34'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 34'd10;
        end
        return p - 34'd1;
    endfunction

    localparam logic [33:0] DEC_MAX = dec_limit(DIGITS);

    // Nibble to active-low segment pattern.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    state_t             state, state_next;
    logic               capture, shift_en, update_en;

    logic [WIDTH-1:0]   val_q;
    logic               mode_q;
    logic               blz_q;
    logic               ovf_q;
    logic [BW-1:0]      bcd;
    logic [BW-1:0]      bcd_adj;
    logic [WIDTH-1:0]   shift_reg;
    logic [CW-1:0]      cnt;

    logic               ovf_in;
    logic [PW-1:0]      val_ext;
    logic [7*DIGITS-1:0] hex_next;

    // Overflow flag computed from the incoming value at capture time.
    assign ovf_in = mode ? (34'(value) > DEC_MAX)
                         : ((34'(value) >> BW) != 34'd0);

    assign val_ext = PW'(val_q);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesised flops.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment at the top of each always_comb keeps every
    // path assigned, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = mode ? SHIFT : UPDATE;
            SHIFT:   if (cnt == CW'(1)) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: datapath strobes and busy.
    always_comb begin
        capture   = (state == IDLE) && load;
        shift_en  = (state == SHIFT);
        update_en = (state == UPDATE);
        busy      = (state != IDLE);
    end

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // Operand capture and the serial binary-to-BCD shifter.
    // NOTE: these datapath registers are plain flops, so they are reset along
    // with the FSM; a stale value can never reach the display after reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            val_q     <= '0;
            mode_q    <= 1'b0;
            blz_q     <= 1'b0;
            ovf_q     <= 1'b0;
            bcd       <= '0;
            shift_reg <= '0;
            cnt       <= '0;
        end else if (capture) begin
            val_q     <= value;
            mode_q    <= mode;
            blz_q     <= blank_lz;
            ovf_q     <= ovf_in;
            bcd       <= '0;
            shift_reg <= value;
            cnt       <= CW'(WIDTH);
        end else if (shift_en) begin
            bcd       <= {bcd_adj[BW-2:0], shift_reg[WIDTH-1]};
            shift_reg <= shift_reg << 1;
            cnt       <= cnt - CW'(1);
        end
    end

    // Segment image for the captured value: dashes on overflow, otherwise
    // hex or BCD digits with optional blanking above the top nonzero digit.
    always_comb begin : build_hex
        logic [3:0] nib;
        logic       seen;
        hex_next = '0;
        nib      = '0;
        seen     = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nib = mode_q ? bcd[4*k +: 4] : val_ext[4*k +: 4];
            if (nib != 4'd0) begin
                seen = 1'b1;
            end
            if (ovf_q) begin
                hex_next[7*k +: 7] = SEG_DASH;
            end else if (blz_q && !seen && (k != 0)) begin
                hex_next[7*k +: 7] = SEG_BLANK;
            end else begin
                hex_next[7*k +: 7] = seg7(nib);
            end
        end
    end

    // Registered display outputs; only UPDATE changes what is shown.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            HEX      <= {DIGITS{SEG_BLANK}};
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= update_en;
            if (update_en) begin
                HEX      <= hex_next;
                overflow <= ovf_q;
            end
        end
    end

endmodule

// File: tb/tb_hex_display_multi.sv
// Directed self-checking bench for hex_display_multi (DIGITS=6, WIDTH=20).
module tb_hex_display_multi;

    localparam int DIGITS = 6;
    localparam int WIDTH  = 20;

    logic                 CLOCK_50;
    logic                 reset;
    logic [WIDTH-1:0]     value;
    logic                 load;
    logic                 mode;
    logic                 blank_lz;
    logic [7*DIGITS-1:0]  HEX;
    logic                 busy;
    logic                 done;
    logic                 overflow;

    int checks   = 0;
    int failures = 0;

    hex_display_multi #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .mode     (mode),
        .blank_lz (blank_lz),
        .HEX      (HEX),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Present a load so that it is sampled at the next edge (edge 0).
    task automatic start(input logic [WIDTH-1:0] v, input logic m, input logic b);
        value    = v;
        mode     = m;
        blank_lz = b;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

    logic [41:0] held;
    int          done_cnt;
    int          busy_cnt;
    bit          hold_ok;

    initial begin
        reset    = 1'b1;
        value    = '0;
        load     = 1'b0;
        mode     = 1'b0;
        blank_lz = 1'b0;

        // 1: reset state
        tick();
        tick();
        check("reset_hex", 64'(HEX), 64'(ALL_BLANK));
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_ovf", 64'(overflow), 64'd0);
        reset = 1'b0;
        tick();

        // 2: hex 0x000A5, no blanking, one-cycle latency
        start(20'h000A5, 1'b0, 1'b0);
        check("hex_busy_e0", 64'(busy), 64'd1);
        check("hex_hold_e0", 64'(HEX), 64'(ALL_BLANK));
        tick();
        check("hex_a5", 64'(HEX),
              64'({7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12}));
        check("hex_done_e1", 64'(done), 64'd1);
        check("hex_busy_e1", 64'(busy), 64'd0);
        tick();
        check("hex_done_e2", 64'(done), 64'd0);

        // 3: decimal 12345 with blanking; display frozen during conversion
        held = HEX;
        start(20'd12345, 1'b1, 1'b1);
        busy_cnt = 0;
        done_cnt = 0;
        hold_ok  = 1'b1;
        if (busy) busy_cnt++;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (HEX !== held) hold_ok = 1'b0;
        end
        check("dec_hold", 64'(hold_ok), 64'd1);
        check("dec_done_early", 64'(done_cnt), 64'd0);
        tick();
        check("dec_busy_len", 64'(busy_cnt), 64'd21);
        check("dec_12345", 64'(HEX),
              64'({7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}));
        check("dec_done", 64'(done), 64'd1);
        check("dec_busy_end", 64'(busy), 64'd0);
        tick();
        check("dec_done_off", 64'(done), 64'd0);

        // 4: decimal overflow, then zero clears it
        start(20'd1000000, 1'b1, 1'b1);
        for (int e = 1; e <= 21; e++) tick();
        check("ovf_hex", 64'(HEX), 64'({6{7'h3F}}));
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_done", 64'(done), 64'd1);
        tick();
        start(20'd0, 1'b1, 1'b1);
        for (int e = 1; e <= 21; e++) tick();
        check("zero_hex", 64'(HEX),
              64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
        check("zero_ovf", 64'(overflow), 64'd0);
        tick();

        // 5: second load while busy is ignored
        start(20'd999999, 1'b1, 1'b0);
        done_cnt = 0;
        for (int e = 1; e <= 30; e++) begin
            if (e == 5) begin
                value = 20'd7;
                mode  = 1'b1;
                load  = 1'b1;
            end
            tick();
            if (e == 5) load = 1'b0;
            if (done) done_cnt++;
            if (e == 21) begin
                check("max_hex", 64'(HEX), 64'({6{7'h10}}));
                check("max_ovf", 64'(overflow), 64'd0);
            end
        end
        check("max_one_done", 64'(done_cnt), 64'd1);
        check("max_idle", 64'(busy), 64'd0);
        check("max_kept", 64'(HEX), 64'({6{7'h10}}));

        // 6: reset mid-conversion, then a fresh hex load
        start(20'd54321, 1'b1, 1'b0);
        for (int e = 1; e <= 9; e++) tick();
        reset = 1'b1;
        tick();
        check("abort_hex", 64'(HEX), 64'(ALL_BLANK));
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        reset = 1'b0;
        done_cnt = 0;
        for (int e = 0; e < 25; e++) begin
            tick();
            if (done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_still_blank", 64'(HEX), 64'(ALL_BLANK));
        start(20'hFFFFF, 1'b0, 1'b0);
        tick();
        check("hex_fffff", 64'(HEX),
              64'({7'h40, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E}));
        check("hex_fffff_done", 64'(done), 64'd1);
        check("hex_fffff_ovf", 64'(overflow), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
